// File: rtl/glitc_threshold_servo.sv
// Closed-loop trigger-threshold servo: counts each channel's triggers per window, then nudges
// that channel's comparator threshold toward a target rate, one channel per cycle.
module glitc_threshold_servo #(
  parameter int NCH        = 4,
  parameter int POWERBITS  = 12,
  parameter int SCALERBITS = 16,
  parameter int PERIOD     = 65536,
  parameter logic [POWERBITS+1:0] INIT_THRESHOLD = 14'h0FFF,
  localparam int THRBITS   = POWERBITS + 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     enable_i,
  input  logic [NCH-1:0]           mask_i,
  input  logic [NCH-1:0]           trig_i,
  input  logic [SCALERBITS-1:0]    goal_i,
  input  logic [SCALERBITS-1:0]    deadband_i,
  input  logic [THRBITS-1:0]       step_i,
  input  logic [THRBITS-1:0]       thr_min_i,
  input  logic [THRBITS-1:0]       thr_max_i,
  input  logic                     load_i,
  input  logic [THRBITS-1:0]       load_value_i,
  output logic [NCH*THRBITS-1:0]   thresholds_o,
  output logic [NCH-1:0]           threshold_update_o,
  output logic                     window_done_o,
  output logic                     busy_o
);
  localparam int CNTW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {IDLE, COUNT, ADJUST} state_t;

  state_t                state;
  logic [CNTW-1:0]       win_cnt;
  logic [IDXW-1:0]       idx;
  logic [SCALERBITS-1:0] scaler [NCH];
  logic [SCALERBITS-1:0] snap [NCH];
  logic [SCALERBITS-1:0] scaler_inc [NCH];
  logic [THRBITS-1:0]    thr [NCH];
  logic [NCH-1:0]        update;
  logic                  window_done;
  logic                  busy;

  logic                  terminal;
  logic [SCALERBITS:0]   band_hi;
  logic [SCALERBITS-1:0] band_lo;
  logic [THRBITS-1:0]    cur_thr;
  logic [SCALERBITS-1:0] cur_snap;
  logic [THRBITS:0]      up_sum;
  logic [THRBITS-1:0]    down_diff;
  logic [THRBITS:0]      cand;
  logic [THRBITS-1:0]    adj_thr;
  logic [THRBITS-1:0]    load_thr;

  // Wide compare so out-of-range values (including an up-step carry) clamp cleanly.
  function automatic logic [THRBITS-1:0] clamp_thr(input logic [THRBITS:0] v);
    if (v > {1'b0, thr_max_i})
      return thr_max_i;
    else if (v < {1'b0, thr_min_i})
      return thr_min_i;
    else
      return v[THRBITS-1:0];
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_chan
      assign thresholds_o[gi*THRBITS +: THRBITS] = thr[gi];
      assign scaler_inc[gi] = (trig_i[gi] && !mask_i[gi] && (scaler[gi] != '1))
                              ? scaler[gi] + 1'b1 : scaler[gi];
    end
  endgenerate

  assign terminal  = (win_cnt == CNTW'(PERIOD - 1));
  assign band_hi   = {1'b0, goal_i} + {1'b0, deadband_i};
  assign band_lo   = (goal_i >= deadband_i) ? goal_i - deadband_i : '0;
  assign cur_thr   = thr[idx];
  assign cur_snap  = snap[idx];
  assign up_sum    = {1'b0, cur_thr} + {1'b0, step_i};
  assign down_diff = (cur_thr >= step_i) ? cur_thr - step_i : '0;

  // A zero lower band can never be undershot, so such a channel is never lowered.
  always_comb begin
    cand = {1'b0, cur_thr};
    if ({1'b0, cur_snap} > band_hi)
      cand = up_sum;
    else if (cur_snap < band_lo)
      cand = {1'b0, down_diff};
    adj_thr  = clamp_thr(cand);
    load_thr = clamp_thr({1'b0, load_value_i});
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      win_cnt     <= '0;
      idx         <= '0;
      update      <= '0;
      window_done <= 1'b0;
      busy        <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        scaler[c] <= '0;
        snap[c]   <= '0;
        thr[c]    <= INIT_THRESHOLD;
      end
    end else begin
      update      <= '0;
      window_done <= 1'b0;
      if (load_i) begin
        for (int c = 0; c < NCH; c++) begin
          thr[c]    <= load_thr;
          scaler[c] <= '0;
        end
        update  <= ~mask_i;
        win_cnt <= '0;
        idx     <= '0;
        busy    <= 1'b0;
        state   <= enable_i ? COUNT : IDLE;
      end else if (!enable_i) begin
        for (int c = 0; c < NCH; c++)
          scaler[c] <= '0;
        win_cnt <= '0;
        idx     <= '0;
        busy    <= 1'b0;
        state   <= IDLE;
      end else begin
        case (state)
          IDLE: state <= COUNT;
          COUNT, ADJUST: begin
            win_cnt <= terminal ? '0 : win_cnt + 1'b1;
            for (int c = 0; c < NCH; c++) begin
              if (terminal) begin
                snap[c]   <= scaler_inc[c];
                scaler[c] <= '0;
              end else begin
                scaler[c] <= scaler_inc[c];
              end
            end
            if (state == ADJUST) begin
              if (!mask_i[idx]) begin
                thr[idx]    <= adj_thr;
                update[idx] <= (adj_thr != cur_thr);
              end
              if (idx == IDXW'(NCH - 1)) begin
                idx   <= '0;
                busy  <= 1'b0;
                state <= COUNT;
              end else begin
                idx <= idx + 1'b1;
              end
            end
            if (terminal) begin
              window_done <= 1'b1;
              idx         <= '0;
              busy        <= 1'b1;
              state       <= ADJUST;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign threshold_update_o = update;
  assign window_done_o      = window_done;
  assign busy_o             = busy;

endmodule

// File: tb/tb_glitc_threshold_servo.sv
// Scoreboard bench for glitc_threshold_servo: directed windows push expected output events,
// a negedge monitor pops and compares each window_done / strobe event as the DUT presents it.
module tb_glitc_threshold_servo;
  localparam int NCH = 4;
  localparam int THRBITS = 14;
  localparam int SB = 4;
  localparam int PERIOD = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic load = 1'b0;
  logic [NCH-1:0] mask = '0;
  logic [NCH-1:0] trig = '0;
  logic [SB-1:0] goal = 4'd10;
  logic [SB-1:0] db = 4'd2;
  logic [THRBITS-1:0] step = 14'd4;
  logic [THRBITS-1:0] tmin = 14'h0000;
  logic [THRBITS-1:0] tmax = 14'h3FFF;
  logic [THRBITS-1:0] lval = 14'h0000;
  logic [NCH*THRBITS-1:0] thr_bus;
  logic [NCH-1:0] upd;
  logic done;
  logic busy;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    int                     cyc;
    logic                   done;
    logic [NCH-1:0]         upd;
    logic                   busy;
    logic [NCH*THRBITS-1:0] thr;
  } ev_t;
  ev_t sb[$];
  logic [THRBITS-1:0] exp_thr [NCH];

  glitc_threshold_servo #(
    .NCH(NCH), .POWERBITS(12), .SCALERBITS(SB), .PERIOD(PERIOD), .INIT_THRESHOLD(14'h0FFF)
  ) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .mask_i(mask), .trig_i(trig),
    .goal_i(goal), .deadband_i(db), .step_i(step), .thr_min_i(tmin), .thr_max_i(tmax),
    .load_i(load), .load_value_i(lval), .thresholds_o(thr_bus),
    .threshold_update_o(upd), .window_done_o(done), .busy_o(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [NCH*THRBITS-1:0] pack_thr();
    logic [NCH*THRBITS-1:0] v;
    for (int c = 0; c < NCH; c++) v[c*THRBITS +: THRBITS] = exp_thr[c];
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_ev(input int at, input logic d, input logic [NCH-1:0] u, input logic b);
    ev_t e;
    e.cyc = at; e.done = d; e.upd = u; e.busy = b; e.thr = pack_thr();
    sb.push_back(e);
  endtask

  // Monitor: every cycle the DUT shows a window pulse or a strobe is one transaction.
  always @(negedge clk) begin
    if (!rst && (done || upd != '0)) begin
      if (sb.size() == 0) begin
        check("unexpected_output", {59'd0, done, upd}, 64'd0);
      end else begin
        ev_t e;
        e = sb.pop_front();
        $display("event cyc=%0d done=%0b upd=%b busy=%0b thr=%h", cyc, done, upd, busy, thr_bus);
        check("event_cycle", 64'(cyc), 64'(e.cyc));
        check("window_done", 64'(done), 64'(e.done));
        check("update_strobes", 64'(upd), 64'(e.upd));
        check("busy", 64'(busy), 64'(e.busy));
        check("thresholds", 64'(thr_bus), 64'(e.thr));
      end
    end
  end

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic begin_window(output int w);
    @(negedge clk);
    enable = 1'b1;
    trig = '0;
    w = cyc + PERIOD + 1;
    push_ev(w, 1'b1, '0, 1'b1);
  endtask

  task automatic drive_trigs(input int c0, input int c1, input int c2, input int c3);
    for (int i = 0; i < PERIOD; i++) begin
      @(negedge clk);
      trig = {(i < c3), (i < c2), (i < c1), (i < c0)};
    end
    @(negedge clk);
    trig = '0;
  endtask

  task automatic expect_adjust(input int w, input logic [THRBITS-1:0] n0, input logic [THRBITS-1:0] n1,
                               input logic [THRBITS-1:0] n2, input logic [THRBITS-1:0] n3);
    logic [THRBITS-1:0] nv [NCH];
    nv[0] = n0; nv[1] = n1; nv[2] = n2; nv[3] = n3;
    for (int c = 0; c < NCH; c++) begin
      if (nv[c] != exp_thr[c]) begin
        exp_thr[c] = nv[c];
        push_ev(w + 1 + c, 1'b0, NCH'(1 << c), (c < NCH - 1));
      end
    end
  endtask

  task automatic run_window(input string name, input int c0, input int c1, input int c2, input int c3,
                            input logic [THRBITS-1:0] n0, input logic [THRBITS-1:0] n1,
                            input logic [THRBITS-1:0] n2, input logic [THRBITS-1:0] n3);
    int w;
    begin_window(w);
    expect_adjust(w, n0, n1, n2, n3);
    drive_trigs(c0, c1, c2, c3);
    wait_cyc(w + NCH + 1);
    enable = 1'b0;
    wait_cyc(w + NCH + 4);
    check({name, "_drained"}, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    int busy_seen;
    int w;
    int m;
    for (int c = 0; c < NCH; c++) exp_thr[c] = 14'h0FFF;

    // Reset and idle with enable low
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_thresholds", 64'(thr_bus), 64'(pack_thr()));
    seen = 0;
    busy_seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (upd != '0 || done) seen++;
      if (busy) busy_seen++;
    end
    check("idle_strobes", 64'(seen), 64'd0);
    check("idle_busy", 64'(busy_seen), 64'd0);
    check("idle_thresholds", 64'(thr_bus), 64'(pack_thr()));

    // ch0 over-rate raises, silent channels lower
    run_window("basic", 64, 0, 0, 0, 14'h1003, 14'h0FFB, 14'h0FFB, 14'h0FFB);

    // Load while idle with a tight upper clamp
    tmax = 14'h1001;
    @(negedge clk);
    load = 1'b1;
    lval = 14'h0FFF;
    m = cyc;
    for (int c = 0; c < NCH; c++) exp_thr[c] = 14'h0FFF;
    push_ev(m + 1, 1'b0, 4'b1111, 1'b0);
    @(negedge clk);
    load = 1'b0;
    wait_cyc(m + 3);
    check("idle_load_drained", 64'(sb.size()), 64'd0);

    // Clamp at max; ch1 at 11 sits inside the deadband
    run_window("clamp1", 64, 11, 0, 0, 14'h1001, 14'h0FFF, 14'h0FFB, 14'h0FFB);
    mask = 4'b0100;
    run_window("clamp2_mask", 64, 11, 64, 0, 14'h1001, 14'h0FFF, 14'h0FFB, 14'h0FF7);
    mask = 4'b0000;

    // Scaler saturation: only an exact 15 holds against goal 15, band 0
    tmax = 14'h3FFF;
    goal = 4'd15;
    db = 4'd0;
    run_window("saturate", 20, 14, 0, 15, 14'h1001, 14'h0FFB, 14'h0FF7, 14'h0FF7);
    goal = 4'd10;
    db = 4'd2;

    // Load lands mid-adjust and restarts the window
    mask = 4'b1000;
    tmax = 14'h2000;
    begin_window(w);
    expect_adjust(w, 14'h0FFD, exp_thr[1], exp_thr[2], exp_thr[3]);
    drive_trigs(0, 0, 0, 0);
    wait_cyc(w + 1);
    load = 1'b1;
    lval = 14'h3FFF;
    for (int c = 0; c < NCH; c++) exp_thr[c] = 14'h2000;
    push_ev(w + 2, 1'b0, 4'b0111, 1'b0);
    push_ev(w + 2 + PERIOD, 1'b1, '0, 1'b1);
    expect_adjust(w + 2 + PERIOD, 14'h1FFC, 14'h1FFC, 14'h1FFC, 14'h2000);
    @(negedge clk);
    load = 1'b0;
    wait_cyc(w + PERIOD + 2 + NCH + 1);
    enable = 1'b0;
    mask = 4'b0000;
    tmax = 14'h3FFF;
    wait_cyc(w + PERIOD + 2 + NCH + 4);
    check("load_adjust_drained", 64'(sb.size()), 64'd0);

    // Enable dropped at adjust idx 1: only ch0 is updated
    begin_window(w);
    exp_thr[0] = 14'h1FF8;
    push_ev(w + 1, 1'b0, 4'b0001, 1'b1);
    drive_trigs(0, 0, 0, 0);
    wait_cyc(w + 1);
    enable = 1'b0;
    wait_cyc(w + 10);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_thresholds", 64'(thr_bus), 64'(pack_thr()));
    check("abort_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
